// File: rtl/bnn_conv_classifier.sv
`default_nettype none
// ==========================================================================
// bnn_conv_classifier : KxK binary conv + per-class dense scores + argmax
// Revision 1.0
// ==========================================================================
module bnn_conv_classifier #(
  parameter int K      = 2,
  parameter int IMG    = 3,
  parameter int NCLASS = 2,
  parameter int AW     = $clog2(K*K + NCLASS*(IMG-K+1)*(IMG-K+1))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             learn_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [7:0]       ld_data_i,
  input  logic             classify_i,
  input  logic [K*K*8-1:0] pixels_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic             busy_o,
  output logic [7:0]       result_o,
  output logic             result_valid_o
);
  localparam int KK   = K*K;
  localparam int NWIN = (IMG-K+1)*(IMG-K+1);
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int IW   = $clog2(NCLASS);
  localparam int CW   = 16 + $clog2(KK);
  localparam int SW   = 9 + $clog2(NWIN);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ARGMAX, DONE} state_t;

  state_t               state_q;
  logic signed [7:0]    kern_q  [KK];
  logic signed [7:0]    wt_q    [NCLASS][NWIN];
  logic signed [SW-1:0] score_q [NCLASS];
  logic signed [SW-1:0] best_q;
  logic [IW-1:0]        best_idx_q, cls_q;
  logic [WW-1:0]        win_q, feat_win_q;
  logic                 feat_q, feat_vld_q;
  logic                 pix_ready_q, busy_q, result_valid_q;
  logic [7:0]           result_q;

  logic signed [15:0]   prod_d [KK];
  logic signed [CW-1:0] conv_d;
  logic                 accept_d, take_d;
  logic signed [SW-1:0] best_d;
  logic [IW-1:0]        best_idx_d;

  always_comb begin
    conv_d = '0;
    for (int i = 0; i < KK; i++) begin
      prod_d[i] = 16'($signed(pixels_i[i*8 +: 8])) * 16'(kern_q[i]);
      conv_d    = conv_d + CW'(prod_d[i]);
    end
  end

  assign accept_d   = pix_ready_q && pix_valid_i;
  // Class 0 seeds the running best; later classes need strictly greater.
  assign take_d     = (cls_q == '0) || (score_q[cls_q] > best_q);
  assign best_d     = take_d ? score_q[cls_q] : best_q;
  assign best_idx_d = take_d ? cls_q : best_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      win_q          <= '0;
      feat_win_q     <= '0;
      feat_q         <= 1'b0;
      feat_vld_q     <= 1'b0;
      cls_q          <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      pix_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      for (int i = 0; i < KK; i++) kern_q[i] <= '0;
      for (int c = 0; c < NCLASS; c++) begin
        score_q[c] <= '0;
        for (int w = 0; w < NWIN; w++) wt_q[c][w] <= '0;
      end
    end else begin
      feat_vld_q     <= 1'b0;
      result_valid_q <= 1'b0;
      if (accept_d) begin
        feat_q     <= ~conv_d[CW-1];
        feat_win_q <= win_q;
        feat_vld_q <= 1'b1;
      end
      if (feat_vld_q) begin
        for (int c = 0; c < NCLASS; c++)
          score_q[c] <= feat_q ? score_q[c] + SW'(wt_q[c][feat_win_q])
                               : score_q[c] - SW'(wt_q[c][feat_win_q]);
      end
      case (state_q)
        IDLE: begin
          if (learn_i) begin
            for (int i = 0; i < KK; i++)
              if (ld_addr_i == AW'(i)) kern_q[i] <= ld_data_i;
            for (int c = 0; c < NCLASS; c++)
              for (int w = 0; w < NWIN; w++)
                if (ld_addr_i == AW'(KK + c*NWIN + w)) wt_q[c][w] <= ld_data_i;
          end else if (classify_i) begin
            state_q     <= RUN;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            win_q       <= '0;
            for (int c = 0; c < NCLASS; c++) score_q[c] <= '0;
          end
        end
        RUN: begin
          if (accept_d) begin
            if (win_q == WW'(NWIN-1)) begin
              win_q       <= '0;
              state_q     <= DRAIN;
              pix_ready_q <= 1'b0;
            end else begin
              win_q <= win_q + WW'(1);
            end
          end
        end
        DRAIN: begin
          state_q <= ARGMAX;
          cls_q   <= '0;
        end
        ARGMAX: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          if (cls_q == IW'(NCLASS-1)) begin
            result_q       <= 8'(best_idx_d);
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            cls_q <= cls_q + IW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          pix_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready_o    = pix_ready_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv_classifier.sv
`default_nettype none
// ==========================================================================
// tb_bnn_conv_classifier : directed scoreboard bench, K=2 / IMG=3 / NCLASS=2
// Revision 1.0
// ==========================================================================
module tb_bnn_conv_classifier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        learn = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        classify = 1'b0;
  logic [31:0] pixels = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, busy, result_valid;
  logic [7:0]  result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [7:0] exp_q [$];

  bnn_conv_classifier dut (
    .clk           (clk),
    .rst           (rst),
    .learn_i       (learn),
    .ld_addr_i     (ld_addr),
    .ld_data_i     (ld_data),
    .classify_i    (classify),
    .pixels_i      (pixels),
    .pix_valid_i   (pix_valid),
    .pix_ready_o   (pix_ready),
    .busy_o        (busy),
    .result_o      (result),
    .result_valid_o(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every result pulse must match the oldest expectation
  // and land four cycles after the last accepted window.
  always @(negedge clk) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", result_valid, 1'b0);
      end else begin
        chk("result", result, exp_q.pop_front());
        chk("latency", cyc, last_acc + 4);
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [7:0] d, input logic with_cls);
    learn = 1'b1; ld_addr = a; ld_data = d; classify = with_cls;
    @(negedge clk);
    learn = 1'b0; classify = 1'b0;
    if (with_cls) chk("learn_wins_busy", busy, 1'b0);
  endtask

  task automatic load_set(input logic [31:0] kw, input logic [31:0] w0,
                          input logic [31:0] w1, input logic with_cls);
    for (int i = 0; i < 4; i++) load(4'(i),     kw[i*8 +: 8], with_cls);
    for (int i = 0; i < 4; i++) load(4'(4 + i), w0[i*8 +: 8], with_cls);
    for (int i = 0; i < 4; i++) load(4'(8 + i), w1[i*8 +: 8], with_cls);
  endtask

  task automatic send_win(input logic [31:0] px);
    int n;
    pixels = px; pix_valid = 1'b1; n = 0;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("win_ready", pix_ready, 1'b1);
    last_acc = cyc;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic start_image();
    classify = 1'b1;
    @(negedge clk);
    classify = 1'b0;
    chk("busy_run", busy, 1'b1);
    chk("ready_run", pix_ready, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("result_pending", exp_q.size(), 0);
    @(negedge clk);
    chk("rv_one_cycle", result_valid, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic run_image(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3,
                           input int gap, input logic mid_learn, input logic [7:0] exp_res);
    logic [31:0] px [4];
    px = '{p0, p1, p2, p3};
    start_image();
    exp_q.push_back(exp_res);
    for (int w = 0; w < 4; w++) begin
      send_win(px[w]);
      if (w < 3) begin
        for (int g = 0; g < gap; g++) begin
          learn = mid_learn && (g == 0); ld_addr = 4'd4; ld_data = 8'h80;
          @(negedge clk);
          learn = 1'b0;
        end
      end
    end
    wait_done();
  endtask

  localparam logic [31:0] XA = 32'h01ffff01;
  localparam logic [31:0] XB = 32'hff0101ff;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_result", result, 8'd0);

    // Default kernel/weights, "X" image back-to-back: scores 4 / -4
    load_set(32'h01ffff01, 32'h01ffff01, 32'hff0101ff, 1'b0);
    run_image(XA, XB, XB, XA, 0, 1'b0, 8'd0);

    // "O" image with 3-cycle gaps; a mid-run write to W[0][0] would flip it to 0
    run_image(XB, XA, XA, XB, 3, 1'b1, 8'd1);
    repeat (4) @(negedge clk);
    chk("result_hold", result, 8'd1);

    // Reset after window 2 discards the image and zeroes everything
    start_image();
    exp_q.push_back(8'd0);
    send_win(XA); send_win(XB); send_win(XB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", pix_ready, 1'b0);
    chk("midrst_result", result, 8'd0);
    chk("midrst_rv", result_valid, 1'b0);
    run_image(XA, XB, XB, XA, 0, 1'b0, 8'd0);

    // Loads with classify held high: learn wins, loads land (O image -> 1)
    load_set(32'h01ffff01, 32'h01ffff01, 32'hff0101ff, 1'b1);
    run_image(XB, XA, XA, XB, 0, 1'b0, 8'd1);

    // All weights zero: tie resolves to class 0
    load_set(32'h01ffff01, 32'h0, 32'h0, 1'b0);
    run_image(XB, XA, XA, XB, 1, 1'b0, 8'd0);

    // conv == 0 in every window must binarise to +1
    load_set(32'h00000101, 32'h01010101, 32'hffffffff, 1'b0);
    run_image(32'h0000ff01, 32'h0000ff01, 32'h0000ff01, 32'h0000ff01, 0, 1'b0, 8'd0);

    // conv = +65536 without wrap -> f=+1 -> scores -4 / 4
    load_set(32'h80808080, 32'hffffffff, 32'h01010101, 1'b0);
    run_image(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080, 2, 1'b0, 8'd1);

    // f=-1 with W=-128 adds +128: scores 512 / -508
    load_set(32'h80808080, 32'h80808080, 32'h7f7f7f7f, 1'b0);
    run_image(32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
